// File: rtl/gsram_8192x2_port_ctrl.sv
// rtl/gsram_8192x2_port_ctrl.sv - two-client request controller for the GSRAM_8192x2 dual-port macro
module gsram_8192x2_port_ctrl #(
    parameter int               ABITS    = 13,
    parameter int               DBITS    = 2,
    parameter bit               INIT_EN  = 1'b1,
    parameter logic [DBITS-1:0] INIT_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             c0_req,
    input  logic             c0_we,
    input  logic [ABITS-1:0] c0_addr,
    input  logic [DBITS-1:0] c0_wdata,
    output logic             c0_gnt,
    output logic             c0_rvalid,
    output logic [DBITS-1:0] c0_rdata,
    input  logic             c1_req,
    input  logic             c1_we,
    input  logic [ABITS-1:0] c1_addr,
    input  logic [DBITS-1:0] c1_wdata,
    output logic             c1_gnt,
    output logic             c1_rvalid,
    output logic [DBITS-1:0] c1_rdata,
    output logic             init_done,
    output logic [ABITS-1:0] mem_a0,
    output logic [ABITS-1:0] mem_a1,
    output logic [DBITS-1:0] mem_d0,
    output logic [DBITS-1:0] mem_d1,
    output logic             mem_we0,
    output logic             mem_we1,
    output logic             mem_ce0,
    output logic             mem_ce1,
    input  logic [DBITS-1:0] mem_q0,
    input  logic [DBITS-1:0] mem_q1
);

    localparam int CW = ABITS - 1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rv0_q, rv1_q;
    logic            block_1;

    // Client 1 loses any same-address contest that involves a write.
    assign block_1 = c0_req & c1_req & (c0_addr == c1_addr) & (c0_we | c1_we);

    // State, clear counter and read-return strobes; in-flight reads die on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT_EN ? ST_INIT : ST_RUN;
            cnt_q   <= '0;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rv0_q   <= c0_gnt & ~c0_we;
            rv1_q   <= c1_gnt & ~c1_we;
        end
    end

    // Next state and macro/grant outputs; everything held at 0 while reset is asserted.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        c0_gnt    = 1'b0;
        c1_gnt    = 1'b0;
        init_done = 1'b0;
        mem_a0    = '0;
        mem_a1    = '0;
        mem_d0    = '0;
        mem_d1    = '0;
        mem_we0   = 1'b0;
        mem_we1   = 1'b0;
        mem_ce0   = 1'b0;
        mem_ce1   = 1'b0;
        if (rst_n) begin
            case (state_q)
                ST_INIT: begin
                    // Each cycle clears one even/odd address pair.
                    mem_ce0 = 1'b1;
                    mem_ce1 = 1'b1;
                    mem_we0 = 1'b1;
                    mem_we1 = 1'b1;
                    mem_a0  = {cnt_q, 1'b0};
                    mem_a1  = {cnt_q, 1'b1};
                    mem_d0  = INIT_VAL;
                    mem_d1  = INIT_VAL;
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == {CW{1'b1}}) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    init_done = 1'b1;
                    c0_gnt    = c0_req;
                    c1_gnt    = c1_req & ~block_1;
                    mem_ce0   = c0_gnt;
                    mem_ce1   = c1_gnt;
                    mem_we0   = c0_gnt & c0_we;
                    mem_we1   = c1_gnt & c1_we;
                    mem_a0    = c0_gnt ? c0_addr  : '0;
                    mem_a1    = c1_gnt ? c1_addr  : '0;
                    mem_d0    = c0_gnt ? c0_wdata : '0;
                    mem_d1    = c1_gnt ? c1_wdata : '0;
                end
                default: begin
                    state_d = ST_INIT;
                end
            endcase
        end
    end

    assign c0_rvalid = rv0_q;
    assign c1_rvalid = rv1_q;
    assign c0_rdata  = rv0_q ? mem_q0 : '0;
    assign c1_rdata  = rv1_q ? mem_q1 : '0;

endmodule

// File: tb/tb_gsram_8192x2_port_ctrl.sv
// tb/tb_gsram_8192x2_port_ctrl.sv - self-checking bench for gsram_8192x2_port_ctrl
module tb_gsram_8192x2_port_ctrl;

    localparam int NCLR = 4096;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        c0_req, c0_we, c1_req, c1_we;
    logic [12:0] c0_addr, c1_addr;
    logic [1:0]  c0_wdata, c1_wdata;
    logic        c0_gnt, c0_rvalid, c1_gnt, c1_rvalid, init_done;
    logic [1:0]  c0_rdata, c1_rdata;
    logic [12:0] mem_a0, mem_a1;
    logic [1:0]  mem_d0, mem_d1, mem_q0, mem_q1;
    logic        mem_we0, mem_we1, mem_ce0, mem_ce1;

    int total = 0;
    int bad   = 0;
    bit done  = 1'b0;

    always #5 clk = ~clk;

    gsram_8192x2_port_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
        .c0_gnt(c0_gnt), .c0_rvalid(c0_rvalid), .c0_rdata(c0_rdata),
        .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
        .c1_gnt(c1_gnt), .c1_rvalid(c1_rvalid), .c1_rdata(c1_rdata),
        .init_done(init_done),
        .mem_a0(mem_a0), .mem_a1(mem_a1), .mem_d0(mem_d0), .mem_d1(mem_d1),
        .mem_we0(mem_we0), .mem_we1(mem_we1), .mem_ce0(mem_ce0), .mem_ce1(mem_ce1),
        .mem_q0(mem_q0), .mem_q1(mem_q1)
    );

    // Macro stand-in: synchronous dual-port array, read data one cycle after the read.
    logic [1:0] macro_arr [0:8191];
    initial begin
        for (int i = 0; i < 8192; i++) macro_arr[i] = 2'($urandom_range(1, 3));
        mem_q0 = 2'b00;
        mem_q1 = 2'b00;
    end
    always @(posedge clk) begin
        if (mem_ce0) begin
            if (mem_we0) macro_arr[mem_a0] <= mem_d0;
            else         mem_q0 <= macro_arr[mem_a0];
        end
        if (mem_ce1) begin
            if (mem_we1) macro_arr[mem_a1] <= mem_d1;
            else         mem_q1 <= macro_arr[mem_a1];
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: array contents, clear progress and outstanding reads.
    logic [1:0] ref_mem [0:8191];
    int         icnt = 0;
    bit         pend0 = 0, pend1 = 0;
    logic [1:0] pdat0, pdat1;

    always @(negedge clk) begin
        if (!done) begin
            if (!rst_n) begin
                icnt  = 0;
                pend0 = 0;
                pend1 = 0;
                chk("rst_gnt", {c0_gnt, c1_gnt}, 0);
                chk("rst_rvalid", {c0_rvalid, c1_rvalid}, 0);
                chk("rst_rdata", {c0_rdata, c1_rdata}, 0);
                chk("rst_mem_ctl", {mem_ce0, mem_ce1, mem_we0, mem_we1}, 0);
                chk("rst_mem_a", int'({mem_a0, mem_a1}), 0);
                chk("rst_init_done", init_done, 0);
            end else if (icnt < NCLR) begin
                chk("init_done_low", init_done, 0);
                chk("init_gnt", {c0_gnt, c1_gnt}, 0);
                chk("init_rvalid", {c0_rvalid, c1_rvalid}, 0);
                chk("init_mem_ctl", {mem_ce0, mem_ce1, mem_we0, mem_we1}, 4'b1111);
                chk("init_a0", mem_a0, 2 * icnt);
                chk("init_a1", mem_a1, 2 * icnt + 1);
                chk("init_d", {mem_d0, mem_d1}, 0);
                icnt++;
                if (icnt == NCLR) for (int i = 0; i < 8192; i++) ref_mem[i] = 2'b00;
            end else begin
                bit e0, e1;
                e0 = c0_req;
                e1 = c1_req && !(c0_req && c0_addr == c1_addr && (c0_we || c1_we));
                chk("run_init_done", init_done, 1);
                chk("c0_gnt", c0_gnt, e0);
                chk("c1_gnt", c1_gnt, e1);
                chk("c0_rvalid", c0_rvalid, pend0);
                chk("c1_rvalid", c1_rvalid, pend1);
                chk("c0_rdata", c0_rdata, pend0 ? pdat0 : 2'b00);
                chk("c1_rdata", c1_rdata, pend1 ? pdat1 : 2'b00);
                chk("mem_ctl0", {mem_ce0, mem_we0}, {e0, e0 && c0_we});
                chk("mem_ctl1", {mem_ce1, mem_we1}, {e1, e1 && c1_we});
                chk("mem_a0", mem_a0, e0 ? c0_addr : 13'd0);
                chk("mem_a1", mem_a1, e1 ? c1_addr : 13'd0);
                chk("mem_d0", mem_d0, e0 ? c0_wdata : 2'd0);
                chk("mem_d1", mem_d1, e1 ? c1_wdata : 2'd0);
                pend0 = e0 && !c0_we;
                pend1 = e1 && !c1_we;
                pdat0 = ref_mem[c0_addr];
                pdat1 = ref_mem[c1_addr];
                if (e0 && c0_we) ref_mem[c0_addr] = c0_wdata;
                if (e1 && c1_we) ref_mem[c1_addr] = c1_wdata;
            end
        end
    end

    task automatic drv(input logic r0, input logic w0, input logic [12:0] a0, input logic [1:0] d0,
                       input logic r1, input logic w1, input logic [12:0] a1, input logic [1:0] d1);
        @(posedge clk); #1;
        c0_req = r0; c0_we = w0; c0_addr = a0; c0_wdata = d0;
        c1_req = r1; c1_we = w1; c1_addr = a1; c1_wdata = d1;
        @(negedge clk);
    endtask

    task automatic wait_init(input string nm, output int n);
        n = 0;
        while (!init_done && n < 5000) begin
            @(negedge clk);
            if (!init_done) n++;
        end
        chk(nm, n, NCLR);
    endtask

    function automatic logic [12:0] rnd_addr();
        if ($urandom_range(0, 1) == 0) return 13'($urandom_range(0, 7));
        return 13'($urandom_range(0, 8191));
    endfunction

    initial begin
        int n, ops, cyc, w1c, maxw;
        bit g0s, g1s;
        rst_n = 1'b0;
        // Held reads of addr 1 (c0) and 8191 (c1) throughout reset and clear.
        c0_req = 1'b1; c0_we = 1'b0; c0_addr = 13'd1;    c0_wdata = 2'b00;
        c1_req = 1'b1; c1_we = 1'b0; c1_addr = 13'd8191; c1_wdata = 2'b00;
        repeat (3) @(negedge clk);
        chk("t1_reset_init_done", init_done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t1_first_clear_a0", mem_a0, 0);
        chk("t1_no_gnt_in_init", {c0_gnt, c1_gnt}, 0);
        n = 1;
        while (!init_done && n < 5000) begin
            @(negedge clk);
            if (!init_done) n++;
        end
        chk("t1_clear_cycles", n, NCLR);
        chk("t1_held_gnt", {c0_gnt, c1_gnt}, 2'b11);
        drv(1, 0, 13'd0, 2'b00, 0, 0, 13'd0, 2'b00);
        chk("t1_rd_1_8191", {c0_rvalid, c0_rdata, c1_rvalid, c1_rdata}, 6'b100100);
        drv(0, 0, 13'd0, 2'b00, 0, 0, 13'd0, 2'b00);
        chk("t1_rd_0", {c0_rvalid, c0_rdata}, 3'b100);

        // c0 write then read back
        drv(1, 1, 13'h0A5, 2'b11, 0, 0, 13'd0, 2'b00);
        chk("t2_wr_gnt", c0_gnt, 1);
        drv(1, 0, 13'h0A5, 2'b00, 0, 0, 13'd0, 2'b00);
        chk("t2_rd_gnt", c0_gnt, 1);
        drv(0, 0, 13'd0, 2'b00, 0, 0, 13'd0, 2'b00);
        chk("t2_rdata", {c0_rvalid, c0_rdata}, 3'b111);

        // write/read conflict: client 0 wins, client 1 retries
        drv(1, 1, 13'h100, 2'b10, 1, 0, 13'h100, 2'b00);
        chk("t3_gnt_conflict", {c0_gnt, c1_gnt}, 2'b10);
        drv(0, 0, 13'd0, 2'b00, 1, 0, 13'h100, 2'b00);
        chk("t3_gnt_retry", {c0_gnt, c1_gnt}, 2'b01);
        drv(0, 0, 13'd0, 2'b00, 0, 0, 13'd0, 2'b00);
        chk("t3_c1_rdata", {c1_rvalid, c1_rdata}, 3'b110);

        // shared-address reads both granted
        drv(0, 0, 13'd0, 2'b00, 1, 1, 13'h1FFF, 2'b01);
        drv(1, 0, 13'h1FFF, 2'b00, 1, 0, 13'h1FFF, 2'b00);
        chk("t4_both_gnt", {c0_gnt, c1_gnt}, 2'b11);
        drv(0, 0, 13'd0, 2'b00, 0, 0, 13'd0, 2'b00);
        chk("t4_both_rdata", {c0_rvalid, c0_rdata, c1_rvalid, c1_rdata}, 6'b101101);

        // random dual-client traffic, requests held until granted
        ops = 0; cyc = 0; g0s = 1; g1s = 1; w1c = 0; maxw = 0;
        while (ops < 10000 && cyc < 40000) begin
            @(posedge clk); #1;
            if (!c0_req || g0s) begin
                c0_req = ($urandom_range(0, 9) < 8); c0_we = 1'($urandom_range(0, 1));
                c0_addr = rnd_addr(); c0_wdata = 2'($urandom_range(0, 3));
            end
            if (!c1_req || g1s) begin
                c1_req = ($urandom_range(0, 9) < 8); c1_we = 1'($urandom_range(0, 1));
                c1_addr = rnd_addr(); c1_wdata = 2'($urandom_range(0, 3));
            end
            @(negedge clk);
            g0s = c0_gnt; g1s = c1_gnt;
            if (c0_req && c0_gnt) ops++;
            if (c1_req && c1_gnt) ops++;
            if (c1_req && !c1_gnt) w1c++; else w1c = 0;
            if (w1c > maxw) maxw = w1c;
            cyc++;
        end
        chk("t6_ops_done", int'(ops >= 10000), 1);
        chk("t6_c1_wait_bounded", int'(maxw <= 50), 1);

        // reset right after a c1 read grant drops the read
        drv(0, 0, 13'd0, 2'b00, 1, 0, 13'h0A5, 2'b00);
        chk("t5_c1_gnt", c1_gnt, 1);
        @(posedge clk); #1;
        rst_n = 1'b0; c1_req = 1'b0;
        @(negedge clk);
        chk("t5_rvalid_dropped", c1_rvalid, 0);
        chk("t5_init_done_low", init_done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_restart_a0", mem_a0, 0);
        chk("t5_restart_ce", {mem_ce0, mem_we0}, 2'b11);
        n = 1;
        while (!init_done && n < 5000) begin
            @(negedge clk);
            if (!init_done) n++;
        end
        chk("t5_clear_cycles", n, NCLR);
        drv(1, 0, 13'h0A5, 2'b00, 0, 0, 13'd0, 2'b00);
        drv(0, 0, 13'd0, 2'b00, 0, 0, 13'd0, 2'b00);
        chk("t5_cleared_rdata", {c0_rvalid, c0_rdata}, 3'b100);

        done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
